// File: rtl/stream_mux2_rr_pkg.sv
// stream_mux2_rr_pkg: arbiter state type and source-select encoding shared by the merger.
package stream_mux2_rr_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2} state_t;
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;
endpackage

// File: rtl/stream_reg.sv
// stream_reg: single-entry valid/ready pipeline register; load_en_o says the slot can take a beat.
module stream_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             load_en_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign load_en_o   = !r_valid || out_ready_i;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load_en_o) begin
            r_valid <= in_valid_i;
            if (in_valid_i) r_data <= in_data_i;
        end
    end
endmodule

// File: rtl/stream_mux2_rr.sv
// stream_mux2_rr: burst-aware round-robin merge of two streams into one registered, source-tagged output.
module stream_mux2_rr
    import stream_mux2_rr_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_last_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_last_i,
    output logic                  o_valid_o,
    input  logic                  o_ready_i,
    output logic [DATA_WIDTH-1:0] o_data_o,
    output logic                  o_last_o,
    output logic                  o_sel_o
);
    localparam int RW = DATA_WIDTH + 2;

    state_t                r_state, w_state_nxt;
    logic                  r_ptr, w_ptr_nxt;
    logic                  w_load_en, w_gnt_a, w_gnt_b, w_a_acc, w_b_acc, w_acc;
    logic                  w_sel, w_last;
    logic [DATA_WIDTH-1:0] w_data;
    logic [RW-1:0]         w_reg_q;

    // In IDLE the grant is combinational so a source switch costs no bubble.
    assign w_gnt_a = r_state == LOCK_A || (r_state == IDLE && a_valid_i && (!b_valid_i || r_ptr == SEL_A));
    assign w_gnt_b = r_state == LOCK_B || (r_state == IDLE && b_valid_i && (!a_valid_i || r_ptr == SEL_B));

    assign a_ready_o = !rst_i && w_load_en && w_gnt_a && a_valid_i;
    assign b_ready_o = !rst_i && w_load_en && w_gnt_b && b_valid_i;
    assign w_a_acc   = a_valid_i && a_ready_o;
    assign w_b_acc   = b_valid_i && b_ready_o;
    assign w_acc     = w_a_acc || w_b_acc;
    assign w_sel     = w_a_acc ? SEL_A : SEL_B;
    assign w_last    = w_a_acc ? a_last_i : b_last_i;
    assign w_data    = w_a_acc ? a_data_i : b_data_i;

    stream_reg #(.WIDTH(RW)) u_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (w_acc),
        .in_data_i   ({w_sel, w_last, w_data}),
        .load_en_o   (w_load_en),
        .out_valid_o (o_valid_o),
        .out_data_o  (w_reg_q),
        .out_ready_i (o_ready_i)
    );

    assign {o_sel_o, o_last_o, o_data_o} = w_reg_q;

    // A finished burst hands priority to the other source.
    always_comb begin
        w_state_nxt = !w_acc ? r_state : w_last ? IDLE : w_a_acc ? LOCK_A : LOCK_B;
        w_ptr_nxt   = (w_acc && w_last) ? ~w_sel : r_ptr;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ptr   <= SEL_A;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end
endmodule

// File: tb/tb_stream_mux2_rr.sv
// tb_stream_mux2_rr: directed and random checks of the round-robin merger against a rule-level model.
module tb_stream_mux2_rr;
    logic       clk = 1'b0;
    logic       rst;
    logic       av, bv, al, bl, oready;
    logic [7:0] ad, bd;
    logic       a_ready, b_ready, o_valid, o_last, o_sel;
    logic [7:0] o_data;

    int n_chk = 0;
    int n_fail = 0;

    logic [8:0] qa[$], qb[$];
    logic [9:0] obs[$];
    int         obs_cyc[$];
    bit         pa = 0, pb = 0;
    int         a_block = 0, b_block = 0, pct = 100, cyc = 0;
    bit         rnd_ready = 0;
    logic       br_last;

    int         m_owner;
    bit         m_pa;
    logic       m_ov, m_ol, m_os;
    logic [7:0] m_od;
    bit         ea, eb;

    stream_mux2_rr #(.DATA_WIDTH(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .a_valid_i (av),
        .a_ready_o (a_ready),
        .a_data_i  (ad),
        .a_last_i  (al),
        .b_valid_i (bv),
        .b_ready_o (b_ready),
        .b_data_i  (bd),
        .b_last_i  (bl),
        .o_valid_o (o_valid),
        .o_ready_i (oready),
        .o_data_o  (o_data),
        .o_last_o  (o_last),
        .o_sel_o   (o_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_chk++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_pa    = 1;
        m_ov    = 0;
        m_od    = '0;
        m_ol    = 0;
        m_os    = 0;
    endtask

    task automatic drive();
        if (!pa && qa.size() > 0 && a_block == 0 && $urandom_range(99) < pct) pa = 1;
        if (!pb && qb.size() > 0 && b_block == 0 && $urandom_range(99) < pct) pb = 1;
        av = pa;
        bv = pb;
        {al, ad} = pa ? qa[0] : {1'b0, 8'($urandom)};
        {bl, bd} = pb ? qb[0] : {1'b0, 8'($urandom)};
    endtask

    // One clock: called at a negedge, checks readies mid-cycle and outputs at the next negedge.
    task automatic step();
        bit ld, ga, gb;
        drive();
        #1;
        ld = !m_ov || oready;
        ga = m_owner == 1 || (m_owner == 0 && av && (!bv || m_pa));
        gb = m_owner == 2 || (m_owner == 0 && bv && (!av || !m_pa));
        ea = ld && ga && av;
        eb = ld && gb && bv;
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        br_last = b_ready;
        if (o_valid && oready) begin
            obs.push_back({o_sel, o_last, o_data});
            obs_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (ea || eb) begin
            m_ov = 1;
            m_os = ea;
            m_ol = ea ? al : bl;
            m_od = ea ? ad : bd;
            if (m_ol) begin
                m_owner = 0;
                m_pa    = !ea;
            end else m_owner = ea ? 1 : 2;
        end else if (oready) m_ov = 0;
        if (ea) begin
            void'(qa.pop_front());
            pa = 0;
        end
        if (eb) begin
            void'(qb.pop_front());
            pb = 0;
        end
        cyc++;
        @(negedge clk);
        chk("o_valid", o_valid, m_ov);
        chk("o_data", o_data, m_od);
        chk("o_last", o_last, m_ol);
        chk("o_sel", o_sel, m_os);
        if (a_block > 0) a_block--;
        if (b_block > 0) b_block--;
    endtask

    task automatic rst_pulse();
        rst = 1;
        av  = 1;
        bv  = 1;
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_o_sel", o_sel, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_valid", o_valid, 0);
        model_reset();
        rst = 0;
        av  = pa;
        bv  = pb;
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || pa || pb || o_valid) && n < budget) begin
            if (rnd_ready) oready = 1'($urandom_range(1));
            step();
            n++;
        end
        chk(tag, n < budget, 1);
    endtask

    initial begin
        logic [9:0] exp_alt[4]   = '{10'h311, 10'h121, 10'h312, 10'h122};
        logic [9:0] exp_burst[4] = '{10'h2A0, 10'h2A1, 10'h3A2, 10'h1B0};
        logic [9:0] exp_gap[3]   = '{10'h201, 10'h302, 10'h1B5};
        rst = 1; av = 0; bv = 0; al = 0; bl = 0; ad = 0; bd = 0; oready = 1;
        model_reset();
        @(negedge clk);
        rst_pulse();

        // alternation of single-beat bursts, first grant after reset goes to A
        qa.push_back(9'h111); qa.push_back(9'h112);
        qb.push_back(9'h121); qb.push_back(9'h122);
        obs.delete(); obs_cyc.delete();
        run_idle("alt_idle", 20);
        chk("alt_count", obs.size(), 4);
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            chk("alt_beat", obs[i], exp_alt[i]);
            chk("alt_back_to_back", obs_cyc[i] - obs_cyc[0], i);
        end

        // burst lock keeps B out until A's last beat
        qa.push_back(9'h0A0); qa.push_back(9'h0A1); qa.push_back(9'h1A2);
        qb.push_back(9'h1B0);
        obs.delete(); obs_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("burst_b_ready", br_last, i == 3);
        end
        run_idle("burst_idle", 20);
        chk("burst_count", obs.size(), 4);
        for (int i = 0; i < obs.size() && i < 4; i++) chk("burst_beat", obs[i], exp_burst[i]);

        // backpressure holds the beat, release drains and loads in one cycle
        qa.push_back(9'h131); qa.push_back(9'h132);
        obs.delete(); obs_cyc.delete();
        step();
        oready = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_data", o_data, 8'h31);
            chk("bp_sel", o_sel, 1);
        end
        oready = 1;
        step();
        chk("bp_next_valid", o_valid, 1);
        chk("bp_next_data", o_data, 8'h32);
        chk("bp_drained", obs.size(), 1);
        run_idle("bp_idle", 20);

        // A pauses mid-burst, B must wait for A's last beat
        qa.push_back(9'h001); qa.push_back(9'h102);
        qb.push_back(9'h1B5);
        obs.delete(); obs_cyc.delete();
        b_block = 1;
        step();
        a_block = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_b_valid", bv, 1);
            chk("gap_b_blocked", br_last, 0);
        end
        run_idle("gap_idle", 20);
        chk("gap_count", obs.size(), 3);
        for (int i = 0; i < obs.size() && i < 3; i++) chk("gap_beat", obs[i], exp_gap[i]);

        // reset mid-burst discards the beat and frees the arbiter
        qa.push_back(9'h041);
        qb.push_back(9'h151);
        b_block = 1;
        step();
        chk("midrst_loaded", o_valid, 1);
        rst_pulse();
        step();
        chk("midrst_b_sel", o_sel, 0);
        chk("midrst_b_data", o_data, 8'h51);
        run_idle("midrst_idle", 20);

        // random bursts, sparse valids and random backpressure
        pct = 60;
        for (int s = 0; s < 40; s++) begin
            int la = $urandom_range(1, 4);
            int lb = $urandom_range(1, 4);
            for (int k = 0; k < la; k++) qa.push_back({k == la - 1, 8'($urandom)});
            for (int k = 0; k < lb; k++) qb.push_back({k == lb - 1, 8'($urandom)});
        end
        rnd_ready = 1;
        run_idle("rand_idle", 4000);
        rnd_ready = 0;
        oready = 1;
        run_idle("rand_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
